strobe_capture_fifo: RTL and testbench
======================================

Name: strobe_capture_fifo

Overview:
- Consumer side of the pulse-latched register path: captures a 32-bit data word on each rising edge of an externally generated write strobe.
- Resynchronises that strobe into the system clock domain and queues captured words in a small FIFO.
- Presents the words to a clocked reader with a valid/ready handshake.
- Sits between a strobe-driven producer (enable-pulse / latch style writer) and synchronous downstream logic.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- SYNC_STAGES, 2, flops in the strobe synchroniser; at least 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_strobe  input  1  asynchronous write strobe; each rising edge means "capture wr_data".
- wr_data  input  WIDTH  write data; stable from strobe rise until strobe fall.
- rd_valid  output  1  FIFO not empty; rd_data is meaningful.
- rd_ready  input  1  reader accepts rd_data this cycle.
- rd_data  output  WIDTH  head-of-FIFO word.
- count  output  $clog2(DEPTH+1)  number of stored words.
- overflow  output  1  sticky flag: a capture was dropped because the FIFO was full.

Behaviour:
- Reset (async assert, sync release): all sync flops, the edge-detect flop, pointers and count go to 0. overflow=0. Storage goes to 0, so rd_data=0. rd_valid=0.
- Strobe contract: high for at least SYNC_STAGES+1 clk periods and low for at least SYNC_STAGES+1 periods between pulses. Shorter pulses are unsupported and may be missed.
- Synchroniser: wr_strobe passes through SYNC_STAGES flops. push = sync_out & ~sync_out_d (one-cycle pulse per rising edge).
- Capture data: wr_data is sampled at the same edge where push is applied. This is legal because wr_data is stable while the strobe is high.
- Latency (SYNC_STAGES=2): strobe first sampled high at edge k gives push high between edges k+1 and k+2. The word is written at edge k+2 and rd_valid=1 after edge k+2.
- Pop: pop = rd_valid & rd_ready. The head advances at that edge. rd_data is combinationally mem[rd_ptr], so the next word is visible immediately after the edge.
- Pointers: log2(DEPTH)-bit read and write pointers wrap naturally from DEPTH-1 to 0. count is tracked explicitly.
- Count update: push only gives count+1; pop only gives count-1; both or neither leaves count unchanged.
- Full (count==DEPTH), push without pop: word dropped, overflow set to 1, pointers and count unchanged.
- Full, push and pop in the same cycle: both happen, count stays DEPTH, no overflow.
- Empty: rd_valid=0 and rd_ready is ignored. A push in the same cycle is not popped; the word appears after the edge.
- overflow stays 1 until rst_n is asserted; there is no other clear.
- Reset mid-operation: queued data is discarded immediately (async). A strobe already high across reset release is detected as a new edge and captured once, SYNC_STAGES+1 edges after release.
- rd_ready asserted while rd_valid=0 has no effect.

Decomposition:
- Shared package: WIDTH/DEPTH defaults, the count-width function (clog2), and the minimum strobe high/low period constant (SYNC_STAGES+1). The bench uses these constants.
- One natural sub-module, sync_rise_detect: SYNC_STAGES-deep synchroniser plus edge-detect flop, async active-low reset. Outputs the one-cycle push pulse.
- FIFO storage and control stay in strobe_capture_fifo.

Test Plan:
- Reset then idle 10 cycles -> rd_valid=0, count=0, overflow=0, rd_data=0.
- Strobe high 4 cycles with wr_data=3 (first sampled at edge k), rd_ready=0 -> rd_valid=1 after edge k+2, rd_data=3, count=1. Then rd_ready=1 for 1 cycle -> count=0, rd_valid=0.
- Five strobes with data 3,4,5,6,7, rd_ready=0, DEPTH=4 -> count=4, overflow=1. Then drain with rd_ready=1 -> reads 3,4,5,6 in order; 7 is absent.
- FIFO full (count=4, data 10..13); 14th strobe's push coincides with rd_ready=1 -> 10 popped, 14 stored, count=4, overflow stays 0. Drain -> reads 11,12,13,14.
- Continuous strobes (period 8 clk) with rd_ready=1 throughout, data 20..29 -> every word read exactly once in order, count never exceeds 1.
- Two words queued, rst_n pulsed low mid-cycle while the strobe is held high -> outputs clear immediately. After release, exactly one word is captured (the current wr_data) after 3 edges, count=1.

Source files
------------

// File: rtl/strobe_capture_fifo_pkg.sv
// Shared constants and helpers for the strobe capture FIFO.
package strobe_capture_fifo_pkg;

  localparam int WIDTH_DEF       = 32;
  localparam int DEPTH_DEF       = 4;
  localparam int SYNC_STAGES_DEF = 2;

  // Shortest legal strobe high (and low) time, in clk periods.
  localparam int STROBE_MIN_CYCLES = SYNC_STAGES_DEF + 1;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/strobe_capture_fifo_sync_rise_detect.sv
// Resynchronises the asynchronous write strobe into clk and emits a
// one-cycle pulse for each rising edge.
module sync_rise_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   edge_q, edge_d;

  // Shift the strobe through the synchroniser; remember the last output.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], strobe_in};
    edge_d = sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~edge_q;

endmodule

// File: rtl/strobe_capture_fifo.sv
// Captures wr_data on each (resynchronised) rising edge of wr_strobe and
// queues it for a valid/ready reader. Drops and flags writes when full.
module strobe_capture_fifo
  import strobe_capture_fifo_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_strobe,
  input  logic [WIDTH-1:0]          wr_data,
  output logic                      rd_valid,
  input  logic                      rd_ready,
  output logic [WIDTH-1:0]          rd_data,
  output logic [cnt_w(DEPTH)-1:0]   count,
  output logic                      overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic             push, pop, full, wr_en;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  sync_rise_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .strobe_in  (wr_strobe),
    .rise_pulse (push)
  );

  assign full     = (count_q == FULL_CNT);
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_en    = push & (~full | pop);

  // Next-state for storage, pointers, occupancy and the sticky overflow flag.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push & ~wr_en);
    if (wr_en) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers; storage is cleared so rd_data reads 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data  = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_strobe_capture_fifo.sv
// Directed bench for strobe_capture_fifo with a scoreboard queue.
module tb_strobe_capture_fifo;
  import strobe_capture_fifo_pkg::*;

  localparam int CW = cnt_w(DEPTH_DEF);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 wr_strobe = 1'b0;
  logic [WIDTH_DEF-1:0] wr_data = '0;
  logic                 rd_valid;
  logic                 rd_ready = 1'b0;
  logic [WIDTH_DEF-1:0] rd_data;
  logic [CW-1:0]        count;
  logic                 overflow;

  int n_total = 0;
  int n_pass  = 0;
  int n_read  = 0;
  logic [31:0] exp_q [$];

  strobe_capture_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_strobe (wr_strobe),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_pulse(input logic [31:0] data, input bit expect_kept,
                              input int hi, input int lo);
    wr_data   = data;
    wr_strobe = 1'b1;
    if (expect_kept) exp_q.push_back(data);
    repeat (hi) tick();
    wr_strobe = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] e;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rd_data, e);
    end
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    // Reset then idle.
    do_reset();
    repeat (10) tick();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", rd_data, 32'd0);

    // Single word latency: strobe first sampled at edge k.
    wr_data = 32'd3; wr_strobe = 1'b1; exp_q.push_back(32'd3);
    tick();  // after k
    check("lat_k", 32'(rd_valid), 32'd0);
    tick();  // after k+1
    check("lat_k1", 32'(rd_valid), 32'd0);
    tick();  // after k+2
    check("lat_k2_valid", 32'(rd_valid), 32'd1);
    check("lat_k2_data", rd_data, 32'd3);
    check("lat_k2_count", 32'(count), 32'd1);
    tick();
    wr_strobe = 1'b0;
    repeat (STROBE_MIN_CYCLES) tick();
    void'(exp_q.pop_front());
    rd_ready = 1'b1; tick(); rd_ready = 1'b0;
    check("pop1_count", 32'(count), 32'd0);
    check("pop1_valid", 32'(rd_valid), 32'd0);

    // Overflow: five writes into four slots; the fifth is dropped.
    for (int i = 3; i <= 7; i++)
      strobe_pulse(32'(i), (i - 3) < DEPTH_DEF, STROBE_MIN_CYCLES, STROBE_MIN_CYCLES);
    check("ovf_count", 32'(count), 32'(DEPTH_DEF));
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int i = 0; i < DEPTH_DEF; i++) pop_check("ovf_drain");
    check("ovf_empty", 32'(rd_valid), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full with simultaneous push and pop.
    do_reset();
    for (int i = 10; i <= 13; i++)
      strobe_pulse(32'(i), 1'b1, STROBE_MIN_CYCLES, STROBE_MIN_CYCLES);
    check("full_count", 32'(count), 32'(DEPTH_DEF));
    wr_data = 32'd14; wr_strobe = 1'b1;
    tick();  // after k
    tick();  // after k+1, push is high now
    check("pp_head", rd_data, exp_q.pop_front());
    rd_ready = 1'b1;
    tick();  // edge k+2: push and pop together
    rd_ready = 1'b0;
    exp_q.push_back(32'd14);
    check("pp_count", 32'(count), 32'(DEPTH_DEF));
    check("pp_ovf", 32'(overflow), 32'd0);
    wr_strobe = 1'b0;
    repeat (STROBE_MIN_CYCLES) tick();
    for (int i = 0; i < DEPTH_DEF; i++) pop_check("pp_drain");
    check("pp_empty", 32'(count), 32'd0);

    // Streaming: strobe period 8, reader always ready.
    rd_ready = 1'b1;
    n_read = 0;
    for (int w = 20; w <= 29; w++) begin
      wr_data = 32'(w); exp_q.push_back(32'(w));
      for (int c = 0; c < 8; c++) begin
        wr_strobe = (c < 4);
        if (rd_valid) begin
          if (exp_q.size() != 0) check("stream_data", rd_data, exp_q.pop_front());
          n_read++;
        end
        check("stream_cnt_le1", 32'(count <= CW'(1)), 32'd1);
        tick();
      end
    end
    wr_strobe = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (rd_valid) begin
        if (exp_q.size() != 0) check("stream_data", rd_data, exp_q.pop_front());
        n_read++;
      end
      tick();
    end
    rd_ready = 1'b0;
    check("stream_reads", 32'(n_read), 32'd10);
    check("stream_sb_left", 32'(exp_q.size()), 32'd0);

    // Reset mid-operation with the strobe held high.
    strobe_pulse(32'd40, 1'b1, STROBE_MIN_CYCLES, STROBE_MIN_CYCLES);
    strobe_pulse(32'd41, 1'b1, STROBE_MIN_CYCLES, STROBE_MIN_CYCLES);
    check("mid_pre_count", 32'(count), 32'd2);
    wr_data = 32'd42; wr_strobe = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_data", rd_data, 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();  // edge 1 after release
    check("rel_e1", 32'(count), 32'd0);
    tick();  // edge 2
    check("rel_e2", 32'(count), 32'd0);
    tick();  // edge 3
    check("rel_e3_count", 32'(count), 32'd1);
    check("rel_e3_data", rd_data, 32'd42);
    exp_q.push_back(32'd42);
    repeat (4) tick();
    check("rel_once", 32'(count), 32'd1);
    wr_strobe = 1'b0;
    repeat (STROBE_MIN_CYCLES) tick();
    pop_check("rel_pop");
    check("rel_final", 32'(count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
